control_decoder: RTL and testbench

Registered main control decoder for the RV32I core. It takes the one-hot instruction-class strobes from the opcode decoder, plus funct7[5] and funct3. It produces the register-file, memory, branch, ALU-operand, immediate-format, next-PC and ALU-operation controls for the datapath. All outputs are registered: one clock of latency, cleared asynchronously by reset.

---
 rtl/control_decoder_pkg.sv | 44 ++++
 rtl/control_decoder_logic.sv | 75 +++++++
 rtl/control_decoder.sv | 92 +++++++++
 tb/tb_control_decoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_decoder_pkg.sv
// Shared types for the RV32I main control decoder: selector encodings, the
// default ALU operation and the packed bundle of all control outputs.
package control_decoder_pkg;

    typedef enum logic [1:0] {
        OpARs1  = 2'b00,
        OpAPc   = 2'b01,
        OpAZero = 2'b10
    } op_a_sel_e;

    typedef enum logic {
        OpBRs2 = 1'b0,
        OpBImm = 1'b1
    } op_b_sel_e;

    typedef enum logic [1:0] {
        ImmI  = 2'b00,
        ImmS  = 2'b01,
        ImmU  = 2'b10,
        ImmSb = 2'b11
    } imm_sel_e;

    typedef enum logic [1:0] {
        NpcPlus4  = 2'b00,
        NpcBranch = 2'b01,
        NpcJal    = 2'b10,
        NpcJalr   = 2'b11
    } npc_sel_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef struct packed {
        logic      write;
        logic      store;
        logic      load;
        logic      branch;
        op_a_sel_e op_a;
        op_b_sel_e op_b;
        imm_sel_e  imm;
        npc_sel_e  npc;
        logic [3:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/control_decoder_logic.sv
// Combinational priority decode of the instruction-class strobes into the
// control bundle. No strobe high yields an all-zero (NOP) bundle.
module control_decoder_logic
    import control_decoder_pkg::*;
(
    input  logic       r_type_i,
    input  logic       i_type_lw_i,
    input  logic       i_type_addi_i,
    input  logic       i_type_jalr_i,
    input  logic       s_type_i,
    input  logic       sb_type_i,
    input  logic       u_type_auipc_i,
    input  logic       u_type_lui_i,
    input  logic       uj_type_i,
    input  logic       func_7_bit_6_i,
    input  logic [2:0] func_3_i,
    output ctrl_t      ctrl_o
);

    // Priority chain: earlier classes win when several strobes are high.
    always_comb begin
        ctrl_o = '0;
        if (r_type_i) begin
            ctrl_o.write = 1'b1;
            ctrl_o.aluop = {func_7_bit_6_i, func_3_i};
        end else if (i_type_lw_i) begin
            ctrl_o.write = 1'b1;
            ctrl_o.load  = 1'b1;
            ctrl_o.op_b  = OpBImm;
            ctrl_o.aluop = ALU_ADD;
        end else if (i_type_addi_i) begin
            ctrl_o.write = 1'b1;
            ctrl_o.op_b  = OpBImm;
            // Only SRAI/SRLI use funct7[5]; other OP-IMM funct3 carry immediate bits there.
            ctrl_o.aluop = {(func_3_i == 3'b101) & func_7_bit_6_i, func_3_i};
        end else if (i_type_jalr_i) begin
            ctrl_o.write = 1'b1;
            ctrl_o.op_b  = OpBImm;
            ctrl_o.npc   = NpcJalr;
            ctrl_o.aluop = ALU_ADD;
        end else if (s_type_i) begin
            ctrl_o.store = 1'b1;
            ctrl_o.op_b  = OpBImm;
            ctrl_o.imm   = ImmS;
            ctrl_o.aluop = ALU_ADD;
        end else if (sb_type_i) begin
            ctrl_o.branch = 1'b1;
            ctrl_o.op_a   = OpAPc;
            ctrl_o.op_b   = OpBImm;
            ctrl_o.imm    = ImmSb;
            ctrl_o.npc    = NpcBranch;
            ctrl_o.aluop  = ALU_ADD;
        end else if (u_type_auipc_i) begin
            ctrl_o.write = 1'b1;
            ctrl_o.op_a  = OpAPc;
            ctrl_o.op_b  = OpBImm;
            ctrl_o.imm   = ImmU;
            ctrl_o.aluop = ALU_ADD;
        end else if (u_type_lui_i) begin
            ctrl_o.write = 1'b1;
            ctrl_o.op_a  = OpAZero;
            ctrl_o.op_b  = OpBImm;
            ctrl_o.imm   = ImmU;
            ctrl_o.aluop = ALU_ADD;
        end else if (uj_type_i) begin
            // J-immediate comes from the dedicated jump adder, so imm stays I.
            ctrl_o.write = 1'b1;
            ctrl_o.op_a  = OpAPc;
            ctrl_o.op_b  = OpBImm;
            ctrl_o.npc   = NpcJal;
            ctrl_o.aluop = ALU_ADD;
        end
    end

endmodule

// File: rtl/control_decoder.sv
// Registered RV32I main control decoder: priority decode followed by one
// asynchronously reset output register (latency 1 cycle).
// Optional macro CONTROL_DECODER_ILLEGAL_EN adds a registered `illegal` flag
// raised when zero or several class strobes are high.
module control_decoder
    import control_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r_type,
    input  logic       i_type_lw,
    input  logic       i_type_addi,
    input  logic       i_type_jalr,
    input  logic       s_type,
    input  logic       sb_type,
    input  logic       u_type_auipc,
    input  logic       u_type_lui,
    input  logic       uj_type,
    input  logic       func_7_bit_6,
    input  logic [2:0] func_3,
    output logic       write,
    output logic       store,
    output logic       load,
    output logic       branch,
    output logic [1:0] alu_operand_a_selector,
    output logic       alu_operand_b_selector,
    output logic [1:0] immediate_selector,
    output logic [1:0] next_pc_selector,
`ifdef CONTROL_DECODER_ILLEGAL_EN
    output logic       illegal,
`endif
    output logic [3:0] alu_operations_selector
);

    ctrl_t ctrl_d, ctrl_q;

    control_decoder_logic u_logic (
        .r_type_i       (r_type),
        .i_type_lw_i    (i_type_lw),
        .i_type_addi_i  (i_type_addi),
        .i_type_jalr_i  (i_type_jalr),
        .s_type_i       (s_type),
        .sb_type_i      (sb_type),
        .u_type_auipc_i (u_type_auipc),
        .u_type_lui_i   (u_type_lui),
        .uj_type_i      (uj_type),
        .func_7_bit_6_i (func_7_bit_6),
        .func_3_i       (func_3),
        .ctrl_o         (ctrl_d)
    );

    // Output register; reset clears every control to the NOP bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

`ifdef CONTROL_DECODER_ILLEGAL_EN
    logic [8:0] strobes;
    logic       illegal_d, illegal_q;

    assign strobes   = {r_type, i_type_lw, i_type_addi, i_type_jalr, s_type,
                        sb_type, u_type_auipc, u_type_lui, uj_type};
    // Legal only when exactly one strobe is set: nonzero and a power of two.
    assign illegal_d = (strobes == 9'd0) || ((strobes & (strobes - 9'd1)) != 9'd0);

    // Registered alongside the controls so it aligns with the same decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

    assign write                   = ctrl_q.write;
    assign store                   = ctrl_q.store;
    assign load                    = ctrl_q.load;
    assign branch                  = ctrl_q.branch;
    assign alu_operand_a_selector  = ctrl_q.op_a;
    assign alu_operand_b_selector  = ctrl_q.op_b;
    assign immediate_selector      = ctrl_q.imm;
    assign next_pc_selector        = ctrl_q.npc;
    assign alu_operations_selector = ctrl_q.aluop;

endmodule

// File: tb/tb_control_decoder.sv
// Self-checking bench for control_decoder against a table-driven reference model.
// Honours CONTROL_DECODER_ILLEGAL_EN when defined.
module tb_control_decoder;

    logic       clk;
    logic       rst_n;
    logic [8:0] s;   // {r, lw, addi, jalr, s, sb, auipc, lui, uj}
    logic       f7;
    logic [2:0] f3;

    logic       write, store, load, branch, b_sel;
    logic [1:0] a_sel, imm_sel, npc_sel;
    logic [3:0] aluop;
`ifdef CONTROL_DECODER_ILLEGAL_EN
    logic       illegal;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    control_decoder dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .r_type                  (s[8]),
        .i_type_lw               (s[7]),
        .i_type_addi             (s[6]),
        .i_type_jalr             (s[5]),
        .s_type                  (s[4]),
        .sb_type                 (s[3]),
        .u_type_auipc            (s[2]),
        .u_type_lui              (s[1]),
        .uj_type                 (s[0]),
        .func_7_bit_6            (f7),
        .func_3                  (f3),
        .write                   (write),
        .store                   (store),
        .load                    (load),
        .branch                  (branch),
        .alu_operand_a_selector  (a_sel),
        .alu_operand_b_selector  (b_sel),
        .immediate_selector      (imm_sel),
        .next_pc_selector        (npc_sel),
`ifdef CONTROL_DECODER_ILLEGAL_EN
        .illegal                 (illegal),
`endif
        .alu_operations_selector (aluop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {write, store, load, branch, a_sel, b_sel, imm_sel, npc_sel, aluop};

    // Per-class fields {write,store,load,branch,a[1:0],b,imm[1:0],npc[1:0]}, index 8 = r_type.
    logic [10:0] cls_tab [9];
    initial begin
        cls_tab[8] = 11'b1000_00_0_00_00; // r
        cls_tab[7] = 11'b1010_00_1_00_00; // lw
        cls_tab[6] = 11'b1000_00_1_00_00; // addi
        cls_tab[5] = 11'b1000_00_1_00_11; // jalr
        cls_tab[4] = 11'b0100_00_1_01_00; // s
        cls_tab[3] = 11'b0001_01_1_11_01; // sb
        cls_tab[2] = 11'b1000_01_1_10_00; // auipc
        cls_tab[1] = 11'b1000_10_1_10_00; // lui
        cls_tab[0] = 11'b1000_01_1_00_10; // uj
    end

    // Reference: highest-priority set strobe selects a table row; aluop from ISA rules.
    function automatic logic [14:0] model(input logic [8:0] st, input logic f7v,
                                          input logic [2:0] f3v);
        for (int i = 8; i >= 0; i--) begin
            if (st[i]) begin
                if (i == 8) return {cls_tab[i], f7v, f3v};
                if (i == 6) return {cls_tab[i], (f3v == 3'd5) && f7v, f3v};
                return {cls_tab[i], 4'b0000};
            end
        end
        return 15'd0;
    endfunction

    function automatic logic model_illegal(input logic [8:0] st);
        return $countones(st) != 1;
    endfunction

    // Drive at negedge, capture on the following posedge, sample 1 time unit later.
    task automatic step(input logic [8:0] st, input logic f7v, input logic [2:0] f3v);
        @(negedge clk);
        s  = st;
        f7 = f7v;
        f3 = f3v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s = 9'h100; f7 = 1'b0; f3 = 3'd0;
        #1;
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0000", obs);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 0000", obs);
        end
`ifdef CONTROL_DECODER_ILLEGAL_EN
        n_checks++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_illegal: got %b expected 0", illegal);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (write !== 1'b1 || aluop !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: write=%b aluop=%b expected write=1 aluop=0000",
                     write, aluop);
        end
    endtask

    task automatic test_single_strobes();
        for (int i = 8; i >= 0; i--) begin
            logic [8:0]  st;
            logic [14:0] exp;
            st  = 9'd1 << i;
            exp = model(st, 1'b0, 3'd0);
            step(st, 1'b0, 3'd0);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_strobe[%0d]: got %b expected %b", i, obs, exp);
            end
`ifdef CONTROL_DECODER_ILLEGAL_EN
            n_checks++;
            if (illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL single_illegal[%0d]: got %b expected 0", i, illegal);
            end
`endif
        end
    endtask

    task automatic test_nop_sweep();
        for (int k = 0; k < 8; k++) begin
            step(9'd0, 1'b1, 3'(k));
            n_checks++;
            if (obs !== 15'd0) begin
                n_fail++;
                $display("FAIL nop_f3=%0d: got %b expected 0", k, obs);
            end
`ifdef CONTROL_DECODER_ILLEGAL_EN
            n_checks++;
            if (illegal !== 1'b1) begin
                n_fail++;
                $display("FAIL nop_illegal f3=%0d: got %b expected 1", k, illegal);
            end
`endif
        end
    endtask

    task automatic test_aluop();
        step(9'h100, 1'b1, 3'd0);
        n_checks++;
        if (aluop !== 4'b1000) begin
            n_fail++;
            $display("FAIL aluop_r_sub: got %b expected 1000", aluop);
        end
        step(9'h040, 1'b1, 3'd0);
        n_checks++;
        if (aluop !== 4'b0000) begin
            n_fail++;
            $display("FAIL aluop_addi_f7: got %b expected 0000", aluop);
        end
        step(9'h040, 1'b1, 3'd5);
        n_checks++;
        if (aluop !== 4'b1101) begin
            n_fail++;
            $display("FAIL aluop_srai: got %b expected 1101", aluop);
        end
        step(9'h040, 1'b1, 3'd1);
        n_checks++;
        if (aluop !== 4'b0001) begin
            n_fail++;
            $display("FAIL aluop_slli_f7: got %b expected 0001", aluop);
        end
    endtask

    task automatic test_priority();
        step(9'h110, 1'b0, 3'd0);   // r_type + s_type
        n_checks++;
        if (store !== 1'b0 || write !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_r_s: store=%b write=%b expected store=0 write=1",
                     store, write);
        end
`ifdef CONTROL_DECODER_ILLEGAL_EN
        n_checks++;
        if (illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_illegal: got %b expected 1", illegal);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [8:0]  st;
            logic        fv;
            logic [2:0]  fu;
            logic [14:0] exp;
            // Bias towards one-hot strobes while still covering multi-hot and none.
            case ($urandom_range(0, 3))
                0, 1:    st = 9'd1 << $urandom_range(0, 8);
                2:       st = 9'($urandom);
                default: st = 9'd0;
            endcase
            fv  = 1'($urandom);
            fu  = 3'($urandom);
            exp = model(st, fv, fu);
            step(st, fv, fu);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] s=%b f7=%b f3=%0d: got %b expected %b",
                         n, st, fv, fu, obs, exp);
            end
`ifdef CONTROL_DECODER_ILLEGAL_EN
            n_checks++;
            if (illegal !== model_illegal(st)) begin
                n_fail++;
                $display("FAIL random_illegal[%0d] s=%b: got %b expected %b",
                         n, st, illegal, model_illegal(st));
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] prev;
        step(9'h002, 1'b0, 3'd0);   // lui
        prev = model(9'h002, 1'b0, 3'd0);
        @(negedge clk);
        s = 9'h008;                  // sb, applied next cycle
        n_checks++;
        if (obs !== prev) begin
            n_fail++;
            $display("FAIL b2b_hold: got %b expected %b", obs, prev);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== model(9'h008, 1'b0, 3'd0)) begin
            n_fail++;
            $display("FAIL b2b_next: got %b expected %b", obs, model(9'h008, 1'b0, 3'd0));
        end
    endtask

    task automatic test_midstream_reset();
        step(9'h080, 1'b0, 3'd0);   // lw
        @(negedge clk);
        s = 9'h004;                  // auipc in flight
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %b expected 0", obs);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++;
            $display("FAIL midreset_drop: got %b expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== model(9'h004, 1'b0, 3'd0)) begin
            n_fail++;
            $display("FAIL midreset_resume: got %b expected %b", obs,
                     model(9'h004, 1'b0, 3'd0));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s     = 9'd0;
        f7    = 1'b0;
        f3    = 3'd0;
        test_reset();
        test_single_strobes();
        test_nop_sweep();
        test_aluop();
        test_priority();
        test_back_to_back();
        test_midstream_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
